// File: rtl/screen_pkg.sv
// Shared definitions for the character screen RAM and its text-mode writers.
package screen_pkg;

    // Visible text area defaults
    localparam int COLS    = 80;
    localparam int ROWS    = 30;

    // Screen RAM address fields: addr = {row, col}
    localparam int ROW_W   = 5;
    localparam int COL_W   = 7;
    localparam int ADDR_W  = ROW_W + COL_W;
    localparam int ASCII_W = 7;

    // Writer sizing
    localparam int VAL_W   = 32;
    localparam int LEN_W   = 6;
    localparam int HEX_LEN = 10;

    // ASCII constants
    localparam logic [ASCII_W-1:0] ASCII_0 = 7'h30;
    localparam logic [ASCII_W-1:0] ASCII_1 = 7'h31;
    localparam logic [ASCII_W-1:0] ASCII_X = 7'h78;
    localparam logic [ASCII_W-1:0] ASCII_A = 7'h41;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_WRITE = 2'd1,
        ST_DONE  = 2'd2
    } wr_state_e;

    // Binary string length: 1..32 pass through, 0 or anything above 32 means 32
    function automatic logic [LEN_W-1:0] clamp_len(input logic [LEN_W-1:0] nbits);
        if (nbits == '0 || nbits > LEN_W'(VAL_W))
            return LEN_W'(VAL_W);
        return nbits;
    endfunction

endpackage

// File: rtl/hex_nibble_to_ascii.sv
// Combinational 4-bit value to uppercase hex ASCII character.
module hex_nibble_to_ascii
    import screen_pkg::*;
(
    input  logic [3:0]         nibble,
    output logic [ASCII_W-1:0] ascii
);

    // 0-9 map onto '0'..'9', 10-15 onto 'A'..'F'
    always_comb begin
        ascii = ASCII_0 + {3'b000, nibble};
        if (nibble > 4'd9)
            ascii = ASCII_A + {3'b000, nibble} - 7'd10;
    end

endmodule

// File: rtl/hex_screen_writer.sv
// Streams a latched 32-bit value into screen RAM, one character per cycle,
// either as "0x" + 8 hex digits or as an N-bit binary string.
module hex_screen_writer
    import screen_pkg::*;
#(
    parameter int NCOLS = COLS,
    parameter int NROWS = ROWS
) (
    input  logic               clock,
    input  logic               reset,
    input  logic               start,
    input  logic               fmt,
    input  logic [LEN_W-1:0]   nbits,
    input  logic [VAL_W-1:0]   value,
    input  logic [ROW_W-1:0]   row,
    input  logic [COL_W-1:0]   col,
    output logic               busy,
    output logic               done,
    output logic               wr_en,
    output logic [ADDR_W-1:0]  wr_addr,
    output logic [ASCII_W-1:0] wr_data
);

    wr_state_e          state;
    logic [VAL_W-1:0]   val_sh;   // next character's source sits at the top
    logic               hex_q;
    logic [LEN_W-1:0]   len_q;
    logic [LEN_W-1:0]   idx_q;    // characters already emitted
    logic [ROW_W-1:0]   row_q;    // position of the next character
    logic [COL_W-1:0]   col_q;

    // Position step: col wraps at the last visible column and carries into row
    function automatic logic [ADDR_W-1:0] advance(input logic [ROW_W-1:0] r,
                                                  input logic [COL_W-1:0] c);
        logic [ROW_W-1:0] nr;
        logic [COL_W-1:0] nc;
        nr = r;
        nc = c + 1'b1;
        if (c == COL_W'(NCOLS - 1)) begin
            nc = '0;
            nr = (r == ROW_W'(NROWS - 1)) ? '0 : r + 1'b1;
        end
        return {nr, nc};
    endfunction

    logic [LEN_W-1:0]   len_in;
    logic [LEN_W-1:0]   shamt;
    logic [VAL_W-1:0]   acc_aligned;
    logic [VAL_W-1:0]   acc_sh;
    logic [ASCII_W-1:0] acc_char;
    logic [ASCII_W-1:0] nib_ascii;
    logic [ASCII_W-1:0] cur_char;
    logic [VAL_W-1:0]   cur_sh;
    logic               last_char;

    hex_nibble_to_ascii u_nib (
        .nibble (val_sh[VAL_W-1 -: 4]),
        .ascii  (nib_ascii)
    );

    // Accept path: binary values are left-aligned so the MSB of the string is bit 31
    always_comb begin
        len_in      = clamp_len(nbits);
        shamt       = LEN_W'(VAL_W) - len_in;
        acc_aligned = value << shamt;
        acc_char    = ASCII_0;
        acc_sh      = value;
        if (fmt) begin
            acc_char = acc_aligned[VAL_W-1] ? ASCII_1 : ASCII_0;
            acc_sh   = acc_aligned << 1;
        end
    end

    // Write path: char 1 of hex is 'x' and consumes no nibble
    always_comb begin
        last_char = (idx_q == len_q);
        cur_char  = val_sh[VAL_W-1] ? ASCII_1 : ASCII_0;
        cur_sh    = val_sh << 1;
        if (hex_q) begin
            if (idx_q == LEN_W'(1)) begin
                cur_char = ASCII_X;
                cur_sh   = val_sh;
            end else begin
                cur_char = nib_ascii;
                cur_sh   = val_sh << 4;
            end
        end
    end

    // Writer FSM; all outputs registered
    always_ff @(posedge clock) begin
        if (reset) begin
            state   <= ST_IDLE;
            busy    <= 1'b0;
            done    <= 1'b0;
            wr_en   <= 1'b0;
            wr_addr <= '0;
            wr_data <= '0;
            val_sh  <= '0;
            hex_q   <= 1'b0;
            len_q   <= '0;
            idx_q   <= '0;
            row_q   <= '0;
            col_q   <= '0;
        end else begin
            case (state)
                ST_IDLE, ST_DONE: begin
                    done  <= 1'b0;
                    busy  <= 1'b0;
                    wr_en <= 1'b0;
                    state <= ST_IDLE;
                    if (start) begin
                        state          <= ST_WRITE;
                        busy           <= 1'b1;
                        wr_en          <= 1'b1;
                        wr_addr        <= {row, col};
                        wr_data        <= acc_char;
                        val_sh         <= acc_sh;
                        hex_q          <= ~fmt;
                        len_q          <= fmt ? len_in : LEN_W'(HEX_LEN);
                        idx_q          <= LEN_W'(1);
                        {row_q, col_q} <= advance(row, col);
                    end
                end
                ST_WRITE: begin
                    if (last_char) begin
                        state <= ST_DONE;
                        busy  <= 1'b0;
                        wr_en <= 1'b0;
                        done  <= 1'b1;
                    end else begin
                        wr_en          <= 1'b1;
                        wr_addr        <= {row_q, col_q};
                        wr_data        <= cur_char;
                        val_sh         <= cur_sh;
                        idx_q          <= idx_q + 1'b1;
                        {row_q, col_q} <= advance(row_q, col_q);
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_hex_screen_writer.sv
// Directed bench for hex_screen_writer.
module tb_hex_screen_writer;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic        start = 1'b0;
    logic        fmt   = 1'b0;
    logic [5:0]  nbits = '0;
    logic [31:0] value = '0;
    logic [4:0]  row   = '0;
    logic [6:0]  col   = '0;
    logic        busy, done, wr_en;
    logic [11:0] wr_addr;
    logic [6:0]  wr_data;

    int checks   = 0;
    int failures = 0;

    hex_screen_writer dut (
        .clock   (clock),
        .reset   (reset),
        .start   (start),
        .fmt     (fmt),
        .nbits   (nbits),
        .value   (value),
        .row     (row),
        .col     (col),
        .busy    (busy),
        .done    (done),
        .wr_en   (wr_en),
        .wr_addr (wr_addr),
        .wr_data (wr_data)
    );

    always #5 clock = ~clock;

    task automatic cyc();
        @(posedge clock);
        #1;
    endtask

    // Pulse start for one edge; returns sampling the first write cycle
    task automatic issue(input logic f, input logic [5:0] nb, input logic [31:0] v,
                         input logic [4:0] r, input logic [6:0] c);
        fmt = f; nbits = nb; value = v; row = r; col = c;
        start = 1'b1;
        cyc();
        start = 1'b0;
        value = 32'hxxxx_xxxx;
        row = 'x; col = 'x; fmt = 1'bx; nbits = 'x;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        cyc(); cyc();
        checks++;
        if ({busy, done, wr_en, wr_addr, wr_data} !== 22'd0) begin
            failures++;
            $display("FAIL reset_state got busy=%b done=%b wr_en=%b addr=%0d data=%h want all zero",
                     busy, done, wr_en, wr_addr, wr_data);
        end
        reset = 1'b0;
        cyc();
        checks++;
        if ({busy, done, wr_en} !== 3'b000) begin
            failures++;
            $display("FAIL idle_after_reset got busy=%b done=%b wr_en=%b want 000", busy, done, wr_en);
        end
    endtask

    task automatic test_hex();
        logic [6:0] exp [10] = '{7'h30, 7'h78, 7'h30, 7'h30, 7'h34, 7'h30, 7'h30, 7'h30, 7'h31, 7'h33};
        issue(1'b0, 6'd0, 32'h0040_0013, 5'd12, 7'd33);
        for (int k = 0; k < 10; k++) begin
            checks++;
            if ({wr_en, busy, done, wr_addr, wr_data} !== {3'b110, 12'(1569 + k), exp[k]}) begin
                failures++;
                $display("FAIL hex_char%0d got en=%b busy=%b done=%b addr=%0d data=%h want 1 1 0 %0d %h",
                         k, wr_en, busy, done, wr_addr, wr_data, 1569 + k, exp[k]);
            end
            cyc();
        end
        checks++;
        if ({wr_en, busy, done} !== 3'b001) begin
            failures++;
            $display("FAIL hex_done got en=%b busy=%b done=%b want 0 0 1", wr_en, busy, done);
        end
        cyc();
        checks++;
        if (done !== 1'b0) begin
            failures++;
            $display("FAIL hex_done_pulse got done=%b want 0", done);
        end
    endtask

    task automatic test_binary();
        logic [6:0] exp [7] = '{7'h30, 7'h31, 7'h31, 7'h30, 7'h30, 7'h31, 7'h31};
        int nbusy = 0;
        issue(1'b1, 6'd7, 32'h0000_0033, 5'd14, 7'd40);
        for (int k = 0; k < 7; k++) begin
            checks++;
            if ({wr_en, wr_addr, wr_data} !== {1'b1, 12'(1832 + k), exp[k]}) begin
                failures++;
                $display("FAIL bin_char%0d got en=%b addr=%0d data=%h want 1 %0d %h",
                         k, wr_en, wr_addr, wr_data, 1832 + k, exp[k]);
            end
            if (busy === 1'b1) nbusy++;
            cyc();
        end
        for (int k = 0; k < 4; k++) begin
            if (busy === 1'b1) nbusy++;
            cyc();
        end
        checks++;
        if (nbusy != 7) begin
            failures++;
            $display("FAIL bin_busy_cycles got %0d want 7", nbusy);
        end
    endtask

    task automatic test_wrap();
        int exp_a [10] = '{716, 717, 718, 719, 768, 769, 770, 771, 772, 773};
        issue(1'b0, 6'd0, 32'h0, 5'd5, 7'd76);
        for (int k = 0; k < 10; k++) begin
            checks++;
            if ({wr_en, wr_addr} !== {1'b1, 12'(exp_a[k])}) begin
                failures++;
                $display("FAIL wrap_col_char%0d got en=%b addr=%0d want 1 %0d", k, wr_en, wr_addr, exp_a[k]);
            end
            cyc();
        end
        cyc();
        issue(1'b0, 6'd0, 32'h0, 5'd29, 7'd79);
        checks++;
        if (wr_addr !== 12'd3791) begin
            failures++;
            $display("FAIL wrap_screen_first got addr=%0d want 3791", wr_addr);
        end
        cyc();
        for (int k = 0; k < 8; k++) begin
            checks++;
            if ({wr_en, wr_addr} !== {1'b1, 12'(k)}) begin
                failures++;
                $display("FAIL wrap_screen_char%0d got en=%b addr=%0d want 1 %0d", k + 1, wr_en, wr_addr, k);
            end
            cyc();
        end
        cyc();
    endtask

    task automatic test_clamp();
        int n;
        logic [6:0] e;
        // nbits=0 on all-ones: 32 x '1'
        issue(1'b1, 6'd0, 32'hFFFF_FFFF, 5'd0, 7'd0);
        n = 0;
        for (int k = 0; k < 40 && wr_en === 1'b1; k++) begin
            checks++;
            if ({wr_addr, wr_data} !== {12'(k), 7'h31}) begin
                failures++;
                $display("FAIL clamp0_char%0d got addr=%0d data=%h want %0d 31", k, wr_addr, wr_data, k);
            end
            n++;
            cyc();
        end
        checks++;
        if (n != 32 || done !== 1'b1) begin
            failures++;
            $display("FAIL clamp0_len got %0d writes done=%b want 32 writes done=1", n, done);
        end
        cyc();
        // nbits=40 on 0x80000001: '1', thirty '0', '1'
        issue(1'b1, 6'd40, 32'h8000_0001, 5'd1, 7'd0);
        n = 0;
        for (int k = 0; k < 40 && wr_en === 1'b1; k++) begin
            e = (k == 0 || k == 31) ? 7'h31 : 7'h30;
            checks++;
            if ({wr_addr, wr_data} !== {12'(128 + k), e}) begin
                failures++;
                $display("FAIL clamp40_char%0d got addr=%0d data=%h want %0d %h", k, wr_addr, wr_data, 128 + k, e);
            end
            n++;
            cyc();
        end
        checks++;
        if (n != 32) begin
            failures++;
            $display("FAIL clamp40_len got %0d writes want 32", n);
        end
        cyc();
    endtask

    task automatic test_back_to_back();
        logic [6:0] exp [10] = '{7'h30, 7'h78, 7'h31, 7'h32, 7'h33, 7'h34, 7'h35, 7'h36, 7'h37, 7'h38};
        logic [6:0] expb [4] = '{7'h31, 7'h30, 7'h31, 7'h30};
        int n = 0;
        int t = 0;
        issue(1'b0, 6'd0, 32'h1234_5678, 5'd3, 7'd0);
        // stray start mid-write must be ignored
        while (wr_en === 1'b1 && t < 30) begin
            checks++;
            if (wr_data !== exp[n % 10]) begin
                failures++;
                $display("FAIL b2b_char%0d got data=%h want %h", n, wr_data, exp[n % 10]);
            end
            start = (n == 3);
            value = 32'hAAAA_AAAA; row = 5'd9; col = 7'd9; fmt = 1'b1; nbits = 6'd2;
            n++; t++;
            cyc();
        end
        start = 1'b0;
        checks++;
        if (n != 10 || done !== 1'b1) begin
            failures++;
            $display("FAIL ignore_start got %0d writes done=%b want 10 writes done=1", n, done);
        end
        // start during DONE: first write on the very next cycle
        issue(1'b1, 6'd4, 32'h0000_000A, 5'd1, 7'd0);
        for (int k = 0; k < 4; k++) begin
            checks++;
            if ({wr_en, busy, wr_addr, wr_data} !== {2'b11, 12'(128 + k), expb[k]}) begin
                failures++;
                $display("FAIL b2b_second_char%0d got en=%b busy=%b addr=%0d data=%h want 1 1 %0d %h",
                         k, wr_en, busy, wr_addr, wr_data, 128 + k, expb[k]);
            end
            cyc();
        end
        checks++;
        if ({wr_en, done} !== 2'b01) begin
            failures++;
            $display("FAIL b2b_second_done got en=%b done=%b want 0 1", wr_en, done);
        end
        cyc();
    endtask

    task automatic test_reset_mid();
        logic [6:0] exp [10] = '{7'h30, 7'h78, 7'h44, 7'h45, 7'h41, 7'h44, 7'h42, 7'h45, 7'h45, 7'h46};
        int ndone = 0;
        issue(1'b0, 6'd0, 32'h0040_0013, 5'd0, 7'd0);
        cyc(); cyc(); cyc();
        checks++;
        if ({wr_en, wr_addr} !== {1'b1, 12'd3}) begin
            failures++;
            $display("FAIL rst_mid_4th got en=%b addr=%0d want 1 3", wr_en, wr_addr);
        end
        reset = 1'b1;
        cyc();
        reset = 1'b0;
        checks++;
        if ({wr_en, busy, done} !== 3'b000) begin
            failures++;
            $display("FAIL rst_mid_after got en=%b busy=%b done=%b want 000", wr_en, busy, done);
        end
        for (int k = 0; k < 12; k++) begin
            if (done === 1'b1 || wr_en === 1'b1) ndone++;
            cyc();
        end
        checks++;
        if (ndone != 0) begin
            failures++;
            $display("FAIL rst_mid_quiet got %0d active cycles want 0", ndone);
        end
        issue(1'b0, 6'd0, 32'hDEAD_BEEF, 5'd2, 7'd0);
        for (int k = 0; k < 10; k++) begin
            checks++;
            if ({wr_en, wr_addr, wr_data} !== {1'b1, 12'(256 + k), exp[k]}) begin
                failures++;
                $display("FAIL rst_restart_char%0d got en=%b addr=%0d data=%h want 1 %0d %h",
                         k, wr_en, wr_addr, wr_data, 256 + k, exp[k]);
            end
            cyc();
        end
        checks++;
        if (done !== 1'b1) begin
            failures++;
            $display("FAIL rst_restart_done got done=%b want 1", done);
        end
        cyc();
    endtask

    initial begin
        test_reset();
        test_hex();
        test_binary();
        test_wrap();
        test_clamp();
        test_back_to_back();
        test_reset_mid();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
